disk_ii_ctrl_n: RTL and testbench
=================================

# disk_ii_ctrl_n

Parametrised Disk II controller core: decodes the 16 slot soft switches, keeps motor/select/Q6/Q7 state, spins drives down, and tracks each drive's head position through a per-drive stepper model. It generalises the two-drive controller to 1–4 drives with configurable spindown and stepper settle time, and adds write-protect sensing. It sits between the slot bus decode and the per-drive track datapaths; the boot ROM and the nibble shifters stay outside.

## Interface
- NUM_DRIVES, 2, number of drives, 1–4.
- SPINDOWN_CYCLES, 14000000, CLK_14M cycles from motor-off to drive inactive. Width is 24 bits.
- STEP_CYCLES, 14000, settle cycles between head steps. Width is 16 bits.
- MAX_HALFTRACK, 69, highest head position in half-tracks.
- CLK_14M  in  1  single clock; everything is rising-edge.
- RESET  in  1  synchronous, active-high.
- DEVICE_SELECT  in  1  slot I/O strobe, level, one or more cycles.
- A  in  4  soft-switch offset.
- DRIVE_BANK  in  1  upper drive-index bit. Sampled on a select switch; ignored when NUM_DRIVES ≤ 2.
- DRIVE_DATA  in  8*NUM_DRIVES  latched read byte per drive.
- WPROT  in  NUM_DRIVES  write-protect sense per drive.
- D_OUT  out  8  data to CPU.
- DRIVE_ACTIVE  out  NUM_DRIVES  motor spinning, one-hot on the selected drive.
- DRIVE_SEL  out  2  selected drive index.
- HALFTRACK  out  7*NUM_DRIVES  head position per drive.
- TRACK  out  6*NUM_DRIVES  HALFTRACK>>1.
- MOTOR_PHASE  out  4  phase magnet state.
- Q6, Q7  out  1 each  mode latches.
- READ_STROBE  out  1  comb: DEVICE_SELECT & A==4'hC.
- WRITE_STROBE  out  1  comb: DEVICE_SELECT & A[3:2]==2'b11 & A[0].

## Operation
- **Switch decode.** Applies on every cycle that DEVICE_SELECT is high, so repeated writes are idempotent.
  - A[3]=0: MOTOR_PHASE[A[2:1]] <= A[0].
  - A[3:1]=100: motor_on <= A[0].
  - A[3:1]=101: DRIVE_SEL <= {DRIVE_BANK & (NUM_DRIVES>2), A[0]}. An index ≥ NUM_DRIVES clamps to NUM_DRIVES-1.
  - A[3:1]=110: Q6 <= A[0].
  - A[3:1]=111: Q7 <= A[0].
- **Spindown.**
  - motor_on=1: clears the counter and sets spinning.
  - Falling edge of motor_on: loads SPINDOWN_CYCLES.
  - Counter nonzero: decrements; spinning clears on the cycle it reaches 0.
  - SPINDOWN_CYCLES=0: spinning clears the cycle after motor_on falls.
  - Motor-on during a countdown cancels the countdown.
- **Drive activity.** DRIVE_ACTIVE[i] = spinning & (DRIVE_SEL==i). A select change while spinning moves activity to the new drive in the same cycle without restarting the spindown.
- **Stepper (per drive)**, with p = halftrack[1:0]. Only the active drive steps.
  - The stepper has two states, IDLE and SETTLE.
  - In IDLE, a step is +1 when phase[(p+1)&3] & ~phase[(p+3)&3], and −1 when phase[(p+3)&3] & ~phase[(p+1)&3].
  - Position clamps to 0..MAX_HALFTRACK. A clamped step does not move the head and does not enter SETTLE.
  - A step loads the settle timer with STEP_CYCLES and moves to SETTLE. SETTLE returns to IDLE when the timer reaches 0.
  - Opposing or no magnets: no step.
- **D_OUT.**
  - Q6=0: DRIVE_DATA[DRIVE_SEL].
  - Q6=1, Q7=0: write-protect status (see Configuration).
  - Otherwise: 8'h00.

## Timing
- Switch state is visible on the cycle after the strobed edge.
- D_OUT is combinational from registers and inputs.
- A step updates HALFTRACK one cycle after the phase register changes. The next step can happen no earlier than STEP_CYCLES+1 cycles later.
- Reset values:
  - MOTOR_PHASE=0, Q6=Q7=0, motor_on=0, DRIVE_SEL=0.
  - Spindown counter=0, DRIVE_ACTIVE=0.
  - HALFTRACK=0 and TRACK=0 for all drives.
  - Steppers in IDLE.
- RESET mid-spindown or mid-settle aborts it immediately.
- Simultaneous strobe and counter expiry: the strobe wins.

## Configuration
- DISKII_WPROT_SENSE_EN defined: with Q6=1, Q7=0, D_OUT={WPROT[DRIVE_SEL],7'b0}.
- Not defined: D_OUT=8'h00 whenever Q6=1. The WPROT input is unused.

## Structure
- Package disk_ii_pkg holds:
  - soft-switch offset constants: PHASE, MOTOR, SELECT, Q6, Q7, DATA=4'hC;
  - the stepper state enum;
  - the default timing constants.
- Sub-module disk_ii_stepper, one instance per drive, owns the halftrack register, the settle timer and the clamp.

## Test plan
- Reset, then A=4'h9 (motor on) and A=4'h8 (motor off) with SPINDOWN_CYCLES=100 -> DRIVE_ACTIVE[0] high, then falls exactly 100 cycles after the off edge.
- From halftrack 0, energise phase 1 then phase 2 with STEP_CYCLES=10, other phases off -> HALFTRACK goes 1 then 2; a second step attempt inside the 10-cycle settle window is deferred.
- At halftrack 0, energise phase 3 only -> HALFTRACK stays 0 and the stepper stays IDLE.
- NUM_DRIVES=4: DRIVE_BANK=1 with A=4'hB while spinning -> DRIVE_SEL=3 and DRIVE_ACTIVE=4'b1000; drive 0's halftrack is frozen.
- Q6=0, DRIVE_DATA[sel]=8'hD5, A=4'hC -> READ_STROBE=1 and D_OUT=8'hD5.
- Macro on, WPROT[0]=1, A=4'hD then A=4'hE -> D_OUT=8'h80. Macro off, same stimulus -> D_OUT=8'h00.

Source files
------------

// File: rtl/disk_ii_pkg.sv
// Shared constants and types for the Disk II controller slice.
// Soft-switch offsets, stepper state encoding and default timing.
package disk_ii_pkg;

    localparam logic [3:0] SW_PHASE  = 4'h0;
    localparam logic [3:0] SW_MOTOR  = 4'h8;
    localparam logic [3:0] SW_SELECT = 4'hA;
    localparam logic [3:0] SW_Q6     = 4'hC;
    localparam logic [3:0] SW_Q7     = 4'hE;
    localparam logic [3:0] SW_DATA   = 4'hC;

    typedef enum logic {
        ST_IDLE,
        ST_SETTLE
    } step_state_e;

    localparam logic [23:0] DEF_SPINDOWN_CYCLES = 24'd14000000;
    localparam logic [15:0] DEF_STEP_CYCLES     = 16'd14000;
    localparam logic [6:0]  DEF_MAX_HALFTRACK   = 7'd69;

endpackage

// File: rtl/disk_ii_ctrl_n_if.sv
// Slot bus bundle: DEVICE_SELECT/A/DRIVE_BANK from the bus decode,
// D_OUT and the read/write strobes back to it.
interface disk_ii_ctrl_n_if;

    logic       DEVICE_SELECT;
    logic [3:0] A;
    logic       DRIVE_BANK;
    logic [7:0] D_OUT;
    logic       READ_STROBE;
    logic       WRITE_STROBE;

    modport master (
        output DEVICE_SELECT, A, DRIVE_BANK,
        input  D_OUT, READ_STROBE, WRITE_STROBE
    );

    modport slave (
        input  DEVICE_SELECT, A, DRIVE_BANK,
        output D_OUT, READ_STROBE, WRITE_STROBE
    );

endinterface

// File: rtl/disk_ii_stepper.sv
// Per-drive head stepper: halftrack register, settle timer, clamp.
// Ports: CLK_14M, RESET, active (drive spinning+selected), phase, halftrack.
module disk_ii_stepper
    import disk_ii_pkg::*;
#(
    parameter logic [15:0] STEP_CYCLES   = DEF_STEP_CYCLES,
    parameter logic [6:0]  MAX_HALFTRACK = DEF_MAX_HALFTRACK
) (
    input  logic       CLK_14M,
    input  logic       RESET,
    input  logic       active,
    input  logic [3:0] phase,
    output logic [6:0] halftrack
);

    step_state_e state_q, state_d;
    logic [6:0]  ht_q, ht_d;
    logic [15:0] tmr_q, tmr_d;
    logic [1:0]  p;
    logic        pull_up, pull_dn;

    // Magnet one position ahead pulls up, one behind pulls down.
    assign p       = ht_q[1:0];
    assign pull_up = phase[p + 2'd1] & ~phase[p + 2'd3];
    assign pull_dn = phase[p + 2'd3] & ~phase[p + 2'd1];

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ht_q    <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            ht_q    <= ht_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ht_d    = ht_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (active) begin
                    if (pull_up && ht_q < MAX_HALFTRACK) begin
                        ht_d    = ht_q + 7'd1;
                        tmr_d   = STEP_CYCLES;
                        state_d = ST_SETTLE;
                    end else if (pull_dn && ht_q != 7'd0) begin
                        ht_d    = ht_q - 7'd1;
                        tmr_d   = STEP_CYCLES;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // Leave on the edge where the timer reaches zero.
                if (tmr_q <= 16'd1) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign halftrack = ht_q;

endmodule

// File: rtl/disk_ii_ctrl_n.sv
// Disk II controller core: soft-switch decode, spindown, per-drive heads.
// Ports: CLK_14M, RESET, bus (slot interface), DRIVE_DATA, WPROT,
// DRIVE_ACTIVE, DRIVE_SEL, HALFTRACK, TRACK, MOTOR_PHASE, Q6, Q7.
// Optional: DISKII_WPROT_SENSE_EN enables write-protect sensing on D_OUT.
module disk_ii_ctrl_n
    import disk_ii_pkg::*;
#(
    parameter int          NUM_DRIVES      = 2,
    parameter logic [23:0] SPINDOWN_CYCLES = DEF_SPINDOWN_CYCLES,
    parameter logic [15:0] STEP_CYCLES     = DEF_STEP_CYCLES,
    parameter logic [6:0]  MAX_HALFTRACK   = DEF_MAX_HALFTRACK
) (
    input  logic                    CLK_14M,
    input  logic                    RESET,
    disk_ii_ctrl_n_if.slave         bus,
    input  logic [8*NUM_DRIVES-1:0] DRIVE_DATA,
    input  logic [NUM_DRIVES-1:0]   WPROT,
    output logic [NUM_DRIVES-1:0]   DRIVE_ACTIVE,
    output logic [1:0]              DRIVE_SEL,
    output logic [7*NUM_DRIVES-1:0] HALFTRACK,
    output logic [6*NUM_DRIVES-1:0] TRACK,
    output logic [3:0]              MOTOR_PHASE,
    output logic                    Q6,
    output logic                    Q7
);

    localparam logic [1:0] LAST_SEL = 2'(NUM_DRIVES - 1);
    localparam logic       BANK_EN  = 1'(NUM_DRIVES > 2);

    logic        wr_phase, wr_motor, wr_select, wr_q6, wr_q7;
    logic [1:0]  sel_idx;
    logic        motor_on, motor_on_nxt, spinning;
    logic [23:0] spin_cnt;
    logic [7:0]  rd_byte, wp_byte;

    always_comb begin
        wr_phase  = 1'b0;
        wr_motor  = 1'b0;
        wr_select = 1'b0;
        wr_q6     = 1'b0;
        wr_q7     = 1'b0;
        if (bus.DEVICE_SELECT) begin
            unique case (1'b1)
                bus.A[3] == SW_PHASE[3]:       wr_phase  = 1'b1;
                bus.A[3:1] == SW_MOTOR[3:1]:   wr_motor  = 1'b1;
                bus.A[3:1] == SW_SELECT[3:1]:  wr_select = 1'b1;
                bus.A[3:1] == SW_Q6[3:1]:      wr_q6     = 1'b1;
                bus.A[3:1] == SW_Q7[3:1]:      wr_q7     = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_idx = {bus.DRIVE_BANK & BANK_EN, bus.A[0]};
        if (sel_idx > LAST_SEL) sel_idx = LAST_SEL;
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            MOTOR_PHASE <= '0;
            motor_on    <= 1'b0;
            DRIVE_SEL   <= '0;
            Q6          <= 1'b0;
            Q7          <= 1'b0;
        end else begin
            if (wr_phase)  MOTOR_PHASE[bus.A[2:1]] <= bus.A[0];
            if (wr_motor)  motor_on  <= bus.A[0];
            if (wr_select) DRIVE_SEL <= sel_idx;
            if (wr_q6)     Q6 <= bus.A[0];
            if (wr_q7)     Q7 <= bus.A[0];
        end
    end

    // Spindown follows the value motor_on takes at this edge, so a
    // motor-on strobe beats a counter expiring on the same cycle.
    assign motor_on_nxt = wr_motor ? bus.A[0] : motor_on;

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            spin_cnt <= '0;
            spinning <= 1'b0;
        end else if (motor_on_nxt) begin
            spin_cnt <= '0;
            spinning <= 1'b1;
        end else if (motor_on) begin
            spin_cnt <= SPINDOWN_CYCLES;
        end else if (spin_cnt != 24'd0) begin
            spin_cnt <= spin_cnt - 24'd1;
            if (spin_cnt == 24'd1) spinning <= 1'b0;
        end else begin
            spinning <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_drv
        assign DRIVE_ACTIVE[i] = spinning & (DRIVE_SEL == 2'(i));

        disk_ii_stepper #(
            .STEP_CYCLES   (STEP_CYCLES),
            .MAX_HALFTRACK (MAX_HALFTRACK)
        ) u_step (
            .CLK_14M   (CLK_14M),
            .RESET     (RESET),
            .active    (DRIVE_ACTIVE[i]),
            .phase     (MOTOR_PHASE),
            .halftrack (HALFTRACK[7*i +: 7])
        );

        assign TRACK[6*i +: 6] = HALFTRACK[7*i+1 +: 6];
    end

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_DRIVES; i++)
            if (DRIVE_SEL == 2'(i)) rd_byte = DRIVE_DATA[8*i +: 8];
    end

`ifdef DISKII_WPROT_SENSE_EN
    always_comb begin
        wp_byte = '0;
        for (int i = 0; i < NUM_DRIVES; i++)
            if (DRIVE_SEL == 2'(i)) wp_byte = {WPROT[i], 7'b0};
    end
`else
    logic unused_wprot;
    assign unused_wprot = ^WPROT;
    assign wp_byte      = 8'h00;
`endif

    assign bus.D_OUT = !Q6 ? rd_byte : (!Q7 ? wp_byte : 8'h00);

    assign bus.READ_STROBE  = bus.DEVICE_SELECT & (bus.A == SW_DATA);
    assign bus.WRITE_STROBE = bus.DEVICE_SELECT & (bus.A[3:2] == 2'b11)
                            & bus.A[0];

endmodule

// File: tb/tb_disk_ii_ctrl_n.sv
// Bench for disk_ii_ctrl_n: decode table, hand corner cases, random vs model.
// Two instances: 4 drives/100-cycle spindown, 3 drives/zero spindown.
module tb_disk_ii_ctrl_n;

    logic clk = 1'b0;
    logic rst;
    int   nchk = 0;
    int   nerr = 0;

    disk_ii_ctrl_n_if bus4 ();
    disk_ii_ctrl_n_if bus3 ();

    assign bus3.DEVICE_SELECT = bus4.DEVICE_SELECT;
    assign bus3.A             = bus4.A;
    assign bus3.DRIVE_BANK    = bus4.DRIVE_BANK;

    logic [31:0] data4;
    logic [3:0]  wp4, act4, ph4;
    logic [1:0]  sel4;
    logic [27:0] ht4;
    logic [23:0] tr4;
    logic        q64, q74;

    logic [23:0] data3;
    logic [2:0]  wp3, act3;
    logic [3:0]  ph3;
    logic [1:0]  sel3;
    logic [20:0] ht3;
    logic [17:0] tr3;
    logic        q63, q73;

    assign data3 = data4[23:0];
    assign wp3   = wp4[2:0];

`ifdef DISKII_WPROT_SENSE_EN
    localparam logic WP_ON = 1'b1;
`else
    localparam logic WP_ON = 1'b0;
`endif

    disk_ii_ctrl_n #(
        .NUM_DRIVES(4), .SPINDOWN_CYCLES(24'd100),
        .STEP_CYCLES(16'd10), .MAX_HALFTRACK(7'd69)
    ) u_dut4 (
        .CLK_14M(clk), .RESET(rst), .bus(bus4),
        .DRIVE_DATA(data4), .WPROT(wp4), .DRIVE_ACTIVE(act4),
        .DRIVE_SEL(sel4), .HALFTRACK(ht4), .TRACK(tr4),
        .MOTOR_PHASE(ph4), .Q6(q64), .Q7(q74)
    );

    disk_ii_ctrl_n #(
        .NUM_DRIVES(3), .SPINDOWN_CYCLES(24'd0),
        .STEP_CYCLES(16'd0), .MAX_HALFTRACK(7'd69)
    ) u_dut3 (
        .CLK_14M(clk), .RESET(rst), .bus(bus3),
        .DRIVE_DATA(data3), .WPROT(wp3), .DRIVE_ACTIVE(act3),
        .DRIVE_SEL(sel3), .HALFTRACK(ht3), .TRACK(tr3),
        .MOTOR_PHASE(ph3), .Q6(q63), .Q7(q73)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [3:0] a, input logic bank = 1'b0);
        bus4.DEVICE_SELECT = 1'b1;
        bus4.A             = a;
        bus4.DRIVE_BANK    = bank;
        cyc();
        bus4.DEVICE_SELECT = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus4.DEVICE_SELECT = 1'b0;
        bus4.A = 4'h0;
        bus4.DRIVE_BANK = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       ds;
        logic [3:0] a;
        logic       bank;
        logic       rs;
        logic       ws;
        logic [3:0] ph;
        logic       q6;
        logic       q7;
        logic [1:0] sel;
        logic [1:0] sel3;
    } vec_t;

    vec_t tbl[15];

    // Reference model: timestamps rather than counters.
    int       t, off_t;
    bit       m_on, mq6, mq7;
    bit [3:0] mph;
    bit [1:0] msel;
    int       mht[4], mrdy[4];

    task automatic model_reset();
        t = 0; off_t = -1000; m_on = 0; mq6 = 0; mq7 = 0;
        mph = 0; msel = 0;
        for (int i = 0; i < 4; i++) begin mht[i] = 0; mrdy[i] = 0; end
    endtask

    initial begin
        logic [3:0] ra;
        logic       rds, rbank, pre_spin, spin_now, up, dn;
        logic [23:0] exp_s;
        logic [51:0] exp_h;
        logic [7:0]  edo;
        int          p;

        tbl[0]  = '{1,4'h1,0,0,0,4'b0001,0,0,2'd0,2'd0};
        tbl[1]  = '{1,4'h5,0,0,0,4'b0101,0,0,2'd0,2'd0};
        tbl[2]  = '{1,4'h0,0,0,0,4'b0100,0,0,2'd0,2'd0};
        tbl[3]  = '{1,4'h7,0,0,0,4'b1100,0,0,2'd0,2'd0};
        tbl[4]  = '{1,4'h4,0,0,0,4'b1000,0,0,2'd0,2'd0};
        tbl[5]  = '{1,4'h6,0,0,0,4'b0000,0,0,2'd0,2'd0};
        tbl[6]  = '{1,4'hD,0,0,1,4'b0000,1,0,2'd0,2'd0};
        tbl[7]  = '{1,4'hF,0,0,1,4'b0000,1,1,2'd0,2'd0};
        tbl[8]  = '{0,4'hC,0,0,0,4'b0000,1,1,2'd0,2'd0};
        tbl[9]  = '{1,4'hE,0,0,0,4'b0000,1,0,2'd0,2'd0};
        tbl[10] = '{1,4'hC,0,1,0,4'b0000,0,0,2'd0,2'd0};
        tbl[11] = '{1,4'hB,1,0,0,4'b0000,0,0,2'd3,2'd2};
        tbl[12] = '{1,4'hA,0,0,0,4'b0000,0,0,2'd0,2'd0};
        tbl[13] = '{1,4'hB,0,0,0,4'b0000,0,0,2'd1,2'd1};
        tbl[14] = '{1,4'hA,1,0,0,4'b0000,0,0,2'd2,2'd2};

        data4 = 32'h44332211;
        wp4   = 4'b0000;
        do_reset();
        chk("reset_act", {act4, 1'b0, act3}, 8'h00);
        chk("reset_regs", {sel4, ph4, q64, q74}, 8'h00);
        chk("reset_head", {ht4, tr4}, 52'h0);
        chk("reset_dout", bus4.D_OUT, 8'h11);

        // Decode table
        foreach (tbl[k]) begin
            bus4.DEVICE_SELECT = tbl[k].ds;
            bus4.A             = tbl[k].a;
            bus4.DRIVE_BANK    = tbl[k].bank;
            #1;
            chk($sformatf("tbl%0d_strobe", k),
                {bus4.READ_STROBE, bus4.WRITE_STROBE},
                {tbl[k].rs, tbl[k].ws});
            cyc();
            bus4.DEVICE_SELECT = 1'b0;
            chk($sformatf("tbl%0d_state", k),
                {ph4, q64, q74, sel4, sel3},
                {tbl[k].ph, tbl[k].q6, tbl[k].q7, tbl[k].sel, tbl[k].sel3});
        end

        // Spindown: 100 cycles on dut4, immediate on dut3
        do_reset();
        sw(4'h9);
        chk("spin_on", {act4, act3}, {4'b0001, 3'b001});
        sw(4'h8);
        chk("spin_off_e0", {act4, act3}, {4'b0001, 3'b001});
        cyc();
        chk("spin_zero_n", {act4, act3}, {4'b0001, 3'b000});
        repeat (98) cyc();
        chk("spin_99", act4, 4'b0001);
        cyc();
        chk("spin_100", act4, 4'b0000);
        // Motor-on on the expiry cycle keeps the drive spinning
        sw(4'h9);
        sw(4'h8);
        repeat (99) cyc();
        sw(4'h9);
        chk("spin_strobe_wins", act4, 4'b0001);
        sw(4'h8);

        // Stepping and settle deferral
        do_reset();
        sw(4'h9);
        sw(4'h3);
        chk("step_e0", ht4[6:0], 7'd0);
        sw(4'h2);
        chk("step_first", ht4[6:0], 7'd1);
        sw(4'h5);
        repeat (9) cyc();
        chk("step_deferred", ht4[6:0], 7'd1);
        cyc();
        chk("step_second", ht4[6:0], 7'd2);
        chk("step_track", tr4[5:0], 6'd1);

        // Four drives: bank select moves activity, drive 0 frozen
        sw(4'hB, 1'b1);
        chk("bank_sel", {sel4, act4, sel3, act3},
            {2'd3, 4'b1000, 2'd2, 3'b100});
        sw(4'h4);
        sw(4'h7);
        repeat (15) cyc();
        chk("frozen_d0", {ht4[6:0], ht4[27:21]}, {7'd2, 7'd0});
        sw(4'h6);
        sw(4'h3);
        cyc();
        chk("d3_steps", {ht4[6:0], ht4[27:21], ht3[20:14]},
            {7'd2, 7'd1, 7'd1});

        // Read data path
        data4[31:24] = 8'hD5;
        bus4.DEVICE_SELECT = 1'b1;
        bus4.A = 4'hC;
        #1;
        chk("read_path", {bus4.READ_STROBE, bus4.D_OUT}, {1'b1, 8'hD5});
        cyc();
        bus4.DEVICE_SELECT = 1'b0;

        // Clamp at zero: no move, stays idle
        do_reset();
        sw(4'h9);
        sw(4'h7);
        repeat (5) cyc();
        chk("clamp_low", ht4[6:0], 7'd0);
        sw(4'h6);
        sw(4'h3);
        cyc();
        chk("clamp_idle", ht4[6:0], 7'd1);

        // Write-protect sense
        wp4 = 4'b0001;
        sw(4'hD);
        sw(4'hE);
        chk("wprot_set", bus4.D_OUT, {WP_ON, 7'b0});
        wp4 = 4'b0000;
        #1;
        chk("wprot_clr", bus4.D_OUT, 8'h00);
        wp4 = 4'b0001;
        sw(4'hF);
        chk("q6q7_zero", bus4.D_OUT, 8'h00);

        // Reset while spinning aborts it
        do_reset();
        chk("reset_abort", {act4, ht4}, 32'h0);

        // Random against model
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rds   = 1'($urandom_range(0, 1));
            ra    = 4'($urandom_range(0, 15));
            rbank = 1'($urandom_range(0, 1));
            bus4.DEVICE_SELECT = rds;
            bus4.A             = ra;
            bus4.DRIVE_BANK    = rbank;
            data4 = $urandom;
            wp4   = 4'($urandom_range(0, 15));
            pre_spin = m_on || (t - off_t < 100);
            cyc();
            t++;
            for (int i = 0; i < 4; i++) begin
                if (pre_spin && msel == 2'(i) && t >= mrdy[i]) begin
                    p  = mht[i] % 4;
                    up = mph[(p + 1) % 4] && !mph[(p + 3) % 4];
                    dn = mph[(p + 3) % 4] && !mph[(p + 1) % 4];
                    if (up && mht[i] < 69) begin
                        mht[i]++; mrdy[i] = t + 11;
                    end else if (dn && mht[i] > 0) begin
                        mht[i]--; mrdy[i] = t + 11;
                    end
                end
            end
            if (rds) begin
                if (!ra[3]) mph[ra[2:1]] = ra[0];
                else if (ra[2:1] == 2'd0) begin
                    if (m_on && !ra[0]) off_t = t;
                    m_on = ra[0];
                end
                else if (ra[2:1] == 2'd1) msel = {rbank, ra[0]};
                else if (ra[2:1] == 2'd2) mq6 = ra[0];
                else mq7 = ra[0];
            end
            spin_now = m_on || (t - off_t < 100);
            if (!mq6) edo = data4[8*msel +: 8];
            else if (!mq7) edo = {WP_ON & wp4[msel], 7'b0};
            else edo = 8'h00;
            exp_s = {spin_now ? 4'(1 << msel) : 4'b0, 2'(msel), 4'(mph),
                     1'(mq6), 1'(mq7), edo, 4'h0};
            for (int i = 0; i < 4; i++) begin
                exp_h[7*i +: 7]      = 7'(mht[i]);
                exp_h[28+6*i +: 6]   = 6'(mht[i] >> 1);
            end
            chk("rand_state", {act4, sel4, ph4, q64, q74, bus4.D_OUT, 4'h0},
                exp_s);
            chk("rand_head", {tr4, ht4}, exp_h);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
